// File: rtl/huff_pkg.sv
// Shared parameters and types for the serial Huffman symbol decoder.
package huff_pkg;

  localparam int unsigned NUM_SYM = 10;
  localparam int unsigned MAX_LEN = 9;
  localparam int unsigned SYM_W   = 4;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned CNT_W   = 8;

  typedef struct packed {
    logic [MAX_LEN-1:0] code;
    logic [LEN_W-1:0]   len;
  } huff_entry_t;

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  // Keeps only the low len bits so stray high code bits can never block a match.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (i < int'(len)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/huff_match_table.sv
// Programmable code table with a combinational lowest-index-first match.
module huff_match_table
  import huff_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [SYM_W-1:0]   addr,
  input  logic [MAX_LEN-1:0] code,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] acc_next,
  input  logic [LEN_W-1:0]   bcnt_next,
  output logic               hit,
  output logic [SYM_W-1:0]   sym
);

  huff_entry_t tbl [NUM_SYM];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SYM); i++) begin
        tbl[i] <= '0;
      end
    end else if (we && (addr < SYM_W'(NUM_SYM))) begin
      tbl[addr] <= '{code: code & len_mask(len), len: len};
    end
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    sym = '0;
    for (int i = int'(NUM_SYM) - 1; i >= 0; i--) begin
      if ((tbl[i].len != '0) && (tbl[i].len == bcnt_next) && (tbl[i].code == acc_next)) begin
        hit = 1'b1;
        sym = SYM_W'(i);
      end
    end
  end

endmodule

// File: rtl/ser2para_decoder.sv
// Splits an MSB-first serial stream of prefix-free codewords back into symbols,
// with per-frame symbol counting and malformed-codeword reporting.
module ser2para_decoder
  import huff_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               tbl_we,
  input  logic [SYM_W-1:0]   tbl_addr,
  input  logic [MAX_LEN-1:0] tbl_code,
  input  logic [LEN_W-1:0]   tbl_len,
  input  logic               ser_start,
  input  logic               ser_data,
  input  logic               ser_done,
  output logic [SYM_W-1:0]   sym_out,
  output logic               sym_valid,
  output logic               frame_done,
  output logic [CNT_W-1:0]   frame_sym_cnt,
  output logic               err_code,
  output logic               err_partial,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]   bcnt_q, bcnt_d;
  logic [CNT_W-1:0]   scnt_q, scnt_d;

  logic [SYM_W-1:0]   sym_out_d;
  logic               sym_valid_d, frame_done_d, err_code_d, err_partial_d;
  logic [CNT_W-1:0]   frame_sym_cnt_d;

  logic [MAX_LEN-1:0] base_acc, acc_next;
  logic [LEN_W-1:0]   base_bcnt, bcnt_next;
  logic [CNT_W-1:0]   base_scnt;
  logic               take_bit, hit;
  logic [SYM_W-1:0]   hit_sym;

  // A start bit always opens a fresh frame, so it is decoded from an empty accumulator.
  assign base_acc  = ser_start ? '0 : acc_q;
  assign base_bcnt = ser_start ? '0 : bcnt_q;
  assign base_scnt = ser_start ? '0 : scnt_q;
  assign acc_next  = {base_acc[MAX_LEN-2:0], ser_data};
  assign bcnt_next = base_bcnt + LEN_W'(1);
  assign take_bit  = ser_start || ((state_q == RECV) && !ser_done);
  assign busy      = (state_q == RECV);

  huff_match_table u_table (
    .clk       (clk),
    .rst       (rst),
    .we        (tbl_we && (state_q == IDLE)),
    .addr      (tbl_addr),
    .code      (tbl_code),
    .len       (tbl_len),
    .acc_next  (acc_next),
    .bcnt_next (bcnt_next),
    .hit       (hit),
    .sym       (hit_sym)
  );

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    bcnt_d          = bcnt_q;
    scnt_d          = scnt_q;
    sym_out_d       = '0;
    sym_valid_d     = 1'b0;
    frame_done_d    = 1'b0;
    frame_sym_cnt_d = frame_sym_cnt;
    err_code_d      = 1'b0;
    err_partial_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ser_start) state_d = RECV;
      end
      RECV: begin
        if (ser_start || ser_done) begin
          frame_done_d    = 1'b1;
          frame_sym_cnt_d = scnt_q;
          err_partial_d   = (bcnt_q != '0);
        end
        if (!ser_start && ser_done) begin
          acc_d   = '0;
          bcnt_d  = '0;
          scnt_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_bit) begin
      if (hit) begin
        sym_out_d   = hit_sym;
        sym_valid_d = 1'b1;
        acc_d       = '0;
        bcnt_d      = '0;
        scnt_d      = (base_scnt == {CNT_W{1'b1}}) ? base_scnt : base_scnt + CNT_W'(1);
      end else if (bcnt_next == LEN_W'(MAX_LEN)) begin
        err_code_d = 1'b1;
        acc_d      = '0;
        bcnt_d     = '0;
        scnt_d     = base_scnt;
      end else begin
        acc_d  = acc_next;
        bcnt_d = bcnt_next;
        scnt_d = base_scnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      bcnt_q        <= '0;
      scnt_q        <= '0;
      sym_out       <= '0;
      sym_valid     <= 1'b0;
      frame_done    <= 1'b0;
      frame_sym_cnt <= '0;
      err_code      <= 1'b0;
      err_partial   <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      bcnt_q        <= bcnt_d;
      scnt_q        <= scnt_d;
      sym_out       <= sym_out_d;
      sym_valid     <= sym_valid_d;
      frame_done    <= frame_done_d;
      frame_sym_cnt <= frame_sym_cnt_d;
      err_code      <= err_code_d;
      err_partial   <= err_partial_d;
    end
  end

endmodule

// File: tb/tb_ser2para_decoder.sv
// Directed bench for ser2para_decoder: decoding, errors, restarts, reset and table locking.
module tb_ser2para_decoder;
  import huff_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               tbl_we = 1'b0;
  logic [SYM_W-1:0]   tbl_addr = '0;
  logic [MAX_LEN-1:0] tbl_code = '0;
  logic [LEN_W-1:0]   tbl_len = '0;
  logic               ser_start = 1'b0;
  logic               ser_data = 1'b0;
  logic               ser_done = 1'b0;
  logic [SYM_W-1:0]   sym_out;
  logic               sym_valid, frame_done, err_code, err_partial, busy;
  logic [CNT_W-1:0]   frame_sym_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic             ov  [0:31];
  logic [SYM_W-1:0] osym[0:31];
  logic             oec [0:31];
  logic             oep [0:31];
  logic             ofd [0:31];
  logic [CNT_W-1:0] ocnt[0:31];

  ser2para_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .tbl_we        (tbl_we),
    .tbl_addr      (tbl_addr),
    .tbl_code      (tbl_code),
    .tbl_len       (tbl_len),
    .ser_start     (ser_start),
    .ser_data      (ser_data),
    .ser_done      (ser_done),
    .sym_out       (sym_out),
    .sym_valid     (sym_valid),
    .frame_done    (frame_done),
    .frame_sym_cnt (frame_sym_cnt),
    .err_code      (err_code),
    .err_partial   (err_partial),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // One clock with the given serial inputs; outputs are stable 1 time unit after the edge.
  task automatic step(input logic s, input logic d, input logic dn);
    ser_start = s;
    ser_data  = d;
    ser_done  = dn;
    @(posedge clk);
    #1;
    ser_start = 1'b0;
    ser_data  = 1'b0;
    ser_done  = 1'b0;
  endtask

  task automatic record(input int i);
    ov[i]   = sym_valid;
    osym[i] = sym_out;
    oec[i]  = err_code;
    oep[i]  = err_partial;
    ofd[i]  = frame_done;
    ocnt[i] = frame_sym_cnt;
  endtask

  task automatic run_frame(input logic [31:0] seq, input int n, input bit with_done);
    for (int i = 0; i < n; i++) begin
      step(i == 0, seq[n-1-i], 1'b0);
      record(i);
    end
    if (with_done) begin
      step(1'b0, 1'b0, 1'b1);
      record(n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic write_entry(input int a, input logic [MAX_LEN-1:0] c, input int l);
    tbl_we   = 1'b1;
    tbl_addr = SYM_W'(a);
    tbl_code = c;
    tbl_len  = LEN_W'(l);
    @(posedge clk);
    #1;
    tbl_we = 1'b0;
  endtask

  // Symbol k<9: k ones then a zero (length k+1); symbol 9: nine ones.
  task automatic load_t();
    for (int k = 0; k < 9; k++) begin
      write_entry(k, ((9'd1 << k) - 9'd1) << 1, k + 1);
    end
    write_entry(9, 9'h1FF, 9);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({sym_out, sym_valid, frame_done, frame_sym_cnt, err_code, err_partial, busy} !== '0) begin
      n_err++;
      $display("FAIL reset: got sym=%0d v=%b fd=%b cnt=%0d ec=%b ep=%b busy=%b, want all 0",
               sym_out, sym_valid, frame_done, frame_sym_cnt, err_code, err_partial, busy);
    end
  endtask

  task automatic test_basic();
    logic             ev;
    logic [SYM_W-1:0] es;
    do_reset();
    load_t();
    run_frame(32'b010110, 6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      ev = (i == 0) || (i == 2) || (i == 5);
      es = (i == 0) ? 4'd0 : (i == 2) ? 4'd1 : (i == 5) ? 4'd2 : 4'd0;
      n_cmp++;
      if (ov[i] !== ev || osym[i] !== es || oec[i] !== 1'b0 || oep[i] !== 1'b0 || ofd[i] !== 1'b0)
      begin
        n_err++;
        $display("FAIL basic bit%0d: got v=%b sym=%0d ec=%b ep=%b fd=%b, want v=%b sym=%0d",
                 i, ov[i], osym[i], oec[i], oep[i], ofd[i], ev, es);
      end
    end
    n_cmp++;
    if (ofd[6] !== 1'b1 || ocnt[6] !== 8'd3 || oep[6] !== 1'b0 || ov[6] !== 1'b0) begin
      n_err++;
      $display("FAIL basic done: got fd=%b cnt=%0d ep=%b v=%b, want fd=1 cnt=3 ep=0 v=0",
               ofd[6], ocnt[6], oep[6], ov[6]);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (frame_sym_cnt !== 8'd3 || frame_done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic hold: got cnt=%0d fd=%b busy=%b, want cnt=3 fd=0 busy=0",
               frame_sym_cnt, frame_done, busy);
    end
  endtask

  task automatic test_long_codes();
    logic             ev;
    logic [SYM_W-1:0] es;
    do_reset();
    load_t();
    run_frame(32'b111111111_111111110, 18, 1'b1);
    for (int i = 0; i < 18; i++) begin
      ev = (i == 8) || (i == 17);
      es = (i == 8) ? 4'd9 : (i == 17) ? 4'd8 : 4'd0;
      n_cmp++;
      if (ov[i] !== ev || osym[i] !== es || oec[i] !== 1'b0) begin
        n_err++;
        $display("FAIL long bit%0d: got v=%b sym=%0d ec=%b, want v=%b sym=%0d ec=0",
                 i, ov[i], osym[i], oec[i], ev, es);
      end
    end
    n_cmp++;
    if (ofd[18] !== 1'b1 || ocnt[18] !== 8'd2 || oep[18] !== 1'b0) begin
      n_err++;
      $display("FAIL long done: got fd=%b cnt=%0d ep=%b, want fd=1 cnt=2 ep=0",
               ofd[18], ocnt[18], oep[18]);
    end
  endtask

  task automatic test_partial();
    do_reset();
    load_t();
    run_frame(32'b11, 2, 1'b1);
    n_cmp++;
    if (ov[0] !== 1'b0 || ov[1] !== 1'b0 || ofd[0] !== 1'b0 || ofd[1] !== 1'b0) begin
      n_err++;
      $display("FAIL partial bits: got v=%b%b fd=%b%b, want v=00 fd=00", ov[0], ov[1], ofd[0],
               ofd[1]);
    end
    n_cmp++;
    if (ofd[2] !== 1'b1 || oep[2] !== 1'b1 || ocnt[2] !== 8'd0 || ov[2] !== 1'b0) begin
      n_err++;
      $display("FAIL partial done: got fd=%b ep=%b cnt=%0d v=%b, want fd=1 ep=1 cnt=0 v=0",
               ofd[2], oep[2], ocnt[2], ov[2]);
    end
  endtask

  task automatic test_bad_code();
    logic             ev, ee;
    logic [SYM_W-1:0] es;
    do_reset();
    write_entry(3, 9'h1FF, 9);
    run_frame({14'd0, 9'h000, 9'h1FF}, 18, 1'b1);
    for (int i = 0; i < 18; i++) begin
      ev = (i == 17);
      ee = (i == 8);
      es = (i == 17) ? 4'd3 : 4'd0;
      n_cmp++;
      if (ov[i] !== ev || osym[i] !== es || oec[i] !== ee) begin
        n_err++;
        $display("FAIL badcode bit%0d: got v=%b sym=%0d ec=%b, want v=%b sym=%0d ec=%b",
                 i, ov[i], osym[i], oec[i], ev, es, ee);
      end
    end
    n_cmp++;
    if (ofd[18] !== 1'b1 || ocnt[18] !== 8'd1 || oep[18] !== 1'b0) begin
      n_err++;
      $display("FAIL badcode done: got fd=%b cnt=%0d ep=%b, want fd=1 cnt=1 ep=0",
               ofd[18], ocnt[18], oep[18]);
    end
  endtask

  task automatic test_restart();
    do_reset();
    load_t();
    run_frame(32'b11, 2, 1'b0);
    run_frame(32'b0, 1, 1'b1);
    n_cmp++;
    if (ofd[0] !== 1'b1 || oep[0] !== 1'b1 || ocnt[0] !== 8'd0 || ov[0] !== 1'b1 ||
        osym[0] !== 4'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL restart: got fd=%b ep=%b cnt=%0d v=%b sym=%0d, want fd=1 ep=1 cnt=0 v=1 sym=0",
               ofd[0], oep[0], ocnt[0], ov[0], osym[0]);
    end
    n_cmp++;
    if (ofd[1] !== 1'b1 || ocnt[1] !== 8'd1 || oep[1] !== 1'b0) begin
      n_err++;
      $display("FAIL restart done: got fd=%b cnt=%0d ep=%b, want fd=1 cnt=1 ep=0",
               ofd[1], ocnt[1], oep[1]);
    end
    // Reset in the middle of a frame.
    run_frame(32'b11, 2, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    n_cmp++;
    if ({sym_out, sym_valid, frame_done, frame_sym_cnt, err_code, err_partial, busy} !== '0) begin
      n_err++;
      $display("FAIL midrst: got sym=%0d v=%b fd=%b cnt=%0d ec=%b ep=%b busy=%b, want all 0",
               sym_out, sym_valid, frame_done, frame_sym_cnt, err_code, err_partial, busy);
    end
    step(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (frame_done !== 1'b0 || err_partial !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle done: got fd=%b ep=%b busy=%b, want 0 0 0", frame_done, err_partial,
               busy);
    end
    step(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (sym_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL table cleared: got v=%b busy=%b, want v=0 busy=1", sym_valid, busy);
    end
    step(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (frame_done !== 1'b1 || frame_sym_cnt !== 8'd0 || err_partial !== 1'b1) begin
      n_err++;
      $display("FAIL cleared done: got fd=%b cnt=%0d ep=%b, want fd=1 cnt=0 ep=1",
               frame_done, frame_sym_cnt, err_partial);
    end
  endtask

  task automatic test_tbl_lock();
    do_reset();
    load_t();
    step(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (sym_valid !== 1'b1 || sym_out !== 4'd0) begin
      n_err++;
      $display("FAIL lock first: got v=%b sym=%0d, want v=1 sym=0", sym_valid, sym_out);
    end
    tbl_we   = 1'b1;
    tbl_addr = 4'd0;
    tbl_code = 9'b11;
    tbl_len  = 4'd2;
    step(1'b0, 1'b0, 1'b0);
    tbl_we = 1'b0;
    n_cmp++;
    if (sym_valid !== 1'b1 || sym_out !== 4'd0) begin
      n_err++;
      $display("FAIL lock write: got v=%b sym=%0d, want v=1 sym=0", sym_valid, sym_out);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (sym_valid !== 1'b0) begin
      n_err++;
      $display("FAIL lock 11: got v=%b sym=%0d, want v=0", sym_valid, sym_out);
    end
    step(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (sym_valid !== 1'b1 || sym_out !== 4'd2) begin
      n_err++;
      $display("FAIL lock 110: got v=%b sym=%0d, want v=1 sym=2", sym_valid, sym_out);
    end
    step(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (frame_done !== 1'b1 || frame_sym_cnt !== 8'd3) begin
      n_err++;
      $display("FAIL lock done: got fd=%b cnt=%0d, want fd=1 cnt=3", frame_done, frame_sym_cnt);
    end
    write_entry(0, 9'b11, 2);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (sym_valid !== 1'b1 || sym_out !== 4'd0) begin
      n_err++;
      $display("FAIL idle write: got v=%b sym=%0d, want v=1 sym=0", sym_valid, sym_out);
    end
    step(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (frame_done !== 1'b1 || frame_sym_cnt !== 8'd1 || err_partial !== 1'b0) begin
      n_err++;
      $display("FAIL idle write done: got fd=%b cnt=%0d ep=%b, want fd=1 cnt=1 ep=0",
               frame_done, frame_sym_cnt, err_partial);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_long_codes();
    test_partial();
    test_bad_code();
    test_restart();
    test_tbl_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
